// File: rtl/fetch_sequencer.sv
// IF stage and IF/ID pipeline register. Handles stall, flush and redirect requests,
// stops fetch on HALT and asserts o_halted once the pipe has drained.
//  state   | meaning
//  S_RUN   | fetching; PC advances unless held by a stall or a HALT
//  S_DRAIN | HALT is in flight; PC frozen, bubbles enter IF/ID, drain counter runs
//  S_DONE  | pipeline drained; everything frozen until reset
module fetch_sequencer #(
  parameter int         N_BITS       = 32,
  parameter logic [5:0] HALT_OPCODE  = 6'h3F,
  parameter int         DRAIN_CYCLES = 4,
  parameter int         CNT_BITS     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_PCSrc,
  input  logic [N_BITS-1:0]   i_jump_direction,
  input  logic [N_BITS-1:0]   i_instruction,
  output logic [N_BITS-1:0]   o_PC,
  output logic [N_BITS-1:0]   o_IF_ID_pc4,
  output logic [N_BITS-1:0]   o_IF_ID_instr,
  output logic                o_IF_ID_valid,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  localparam int DC_BITS = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DC_BITS-1:0]  drain_q, drain_d;
  logic [N_BITS-1:0]   pc_d, pc4_d, instr_d;
  logic                valid_d, halted_d;
  logic [CNT_BITS-1:0] count_d;
  logic [N_BITS-1:0]   pc_plus4;
  logic                is_halt;

  assign pc_plus4 = o_PC + N_BITS'(4);
  assign is_halt  = (i_instruction[N_BITS-1 -: 6] == HALT_OPCODE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       state_q <= S_RUN;
    else if (i_enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!i_PCSrc && !i_stall && !i_flush && is_halt) state_d = S_DRAIN;
      S_DRAIN: begin
        if (i_PCSrc)                         state_d = S_RUN;
        else if (!i_stall && drain_q == '0)  state_d = S_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d     = o_PC;
    pc4_d    = o_IF_ID_pc4;
    instr_d  = o_IF_ID_instr;
    valid_d  = o_IF_ID_valid;
    halted_d = o_halted;
    drain_d  = drain_q;
    count_d  = o_cycle_count;
    if (state_q != S_DONE && o_cycle_count != '1)
      count_d = o_cycle_count + CNT_BITS'(1);
    case (state_q)
      S_RUN: begin
        if (i_PCSrc) begin
          pc_d    = i_jump_direction;
          pc4_d   = '0;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (i_stall) begin
          pc_d = o_PC;
        end else if (i_flush) begin
          pc_d    = pc_plus4;
          pc4_d   = '0;
          instr_d = '0;
          valid_d = 1'b0;
        end else begin
          // HALT is latched like any instruction but the PC stays on it
          pc_d    = is_halt ? o_PC : pc_plus4;
          pc4_d   = pc_plus4;
          instr_d = i_instruction;
          valid_d = 1'b1;
          if (is_halt) drain_d = DC_BITS'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        if (i_PCSrc) begin
          pc_d    = i_jump_direction;
          pc4_d   = '0;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!i_stall) begin
          pc4_d   = '0;
          instr_d = '0;
          valid_d = 1'b0;
          if (drain_q == '0) halted_d = 1'b1;
          else               drain_d  = drain_q - DC_BITS'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_PC          <= '0;
      o_IF_ID_pc4   <= '0;
      o_IF_ID_instr <= '0;
      o_IF_ID_valid <= 1'b0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
      drain_q       <= '0;
    end else if (i_enable) begin
      o_PC          <= pc_d;
      o_IF_ID_pc4   <= pc4_d;
      o_IF_ID_instr <= instr_d;
      o_IF_ID_valid <= valid_d;
      o_halted      <= halted_d;
      o_cycle_count <= count_d;
      drain_q       <= drain_d;
    end
  end

endmodule
